// File: rtl/rgb2dram.sv
// Pixel-stream to DRAM write-burst bridge: buffers 32-bit pixels in a FWFT FIFO and
// requests one DRAM write burst via kick/busy each time a full burst is buffered.
module rgb2dram #(
    parameter logic [31:0] AMOUNT_OF_ONCE = 32'd64,
    parameter int          FIFO_DEPTH     = 256,
    parameter logic [31:0] OFFSET_END     = 32'd1440000,
    localparam int         AW             = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   rgb_in,
    input  logic          rgb_we,
    output logic          rgb_ready,
    output logic          overflow,
    output logic          kick,
    input  logic          busy,
    output logic [31:0]   write_num,
    output logic [31:0]   write_addr,
    output logic [31:0]   buf_din,
    input  logic          buf_re,
    input  logic          frame_select,
    output logic          final_o,
    output logic [AW:0]   fifo_cnt,
    output logic [2:0]    state_o
);

    typedef enum logic [2:0] {
        S_RST      = 3'd0,
        S_RST_WAIT = 3'd1,
        S_IDLE     = 3'd2,
        S_KICK     = 3'd3,
        S_DRAIN    = 3'd4,
        S_END      = 3'd5
    } state_t;

    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [AW:0]   CNT_ONE   = 1;

    state_t        state_q, state_d;
    logic [31:0]   offset_q, offset_d;
    logic [31:0]   pops_q, pops_d;
    logic [31:0]   base_addr_q;
    logic [1:0]    busy_clk_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          overflow_q, overflow_d;
    logic          avail_q;
    logic [31:0]   cnt_ext;
    logic          push, pop;

    logic [31:0]   mem [FIFO_DEPTH];

    // rgb_ready is registered, so a write against a full FIFO is dropped even if a pop lands the same cycle.
    assign push    = rgb_we && ready_q;
    assign pop     = buf_re && (cnt_q != '0);
    assign cnt_ext = 32'(cnt_q);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_ONE;
        end
        if (rgb_we && !ready_q) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        pops_d   = pops_q;
        unique case (state_q)
            S_RST:      state_d = S_RST_WAIT;
            S_RST_WAIT: state_d = S_IDLE;
            S_IDLE: begin
                if (!busy_clk_q[1] && avail_q) begin
                    state_d = S_KICK;
                end
            end
            S_KICK: begin
                if (busy_clk_q[1]) begin
                    offset_d = offset_q + AMOUNT_OF_ONCE;
                    pops_d   = '0;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Saturate at a full burst so stray extra pops cannot skip the exit condition.
                if (pop && (pops_q != AMOUNT_OF_ONCE)) begin
                    pops_d = pops_q + 32'd1;
                end
                if ((pops_q == AMOUNT_OF_ONCE) && !busy_clk_q[1]) begin
                    state_d = (offset_q == OFFSET_END) ? S_END : S_IDLE;
                end
            end
            S_END:      state_d = S_END;
            default:    state_d = S_RST;
        endcase
        ready_d = (state_d != S_RST) && (state_d != S_RST_WAIT) && (cnt_d != DEPTH_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RST;
            offset_q    <= '0;
            pops_q      <= '0;
            base_addr_q <= frame_select ? 32'h0 : 32'h100_0000;
            busy_clk_q  <= 2'b00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            overflow_q  <= 1'b0;
            avail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            pops_q     <= pops_d;
            busy_clk_q <= {busy_clk_q[0], busy};
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
            // Extra register stage keeps the first kick at least two cycles after the filling write.
            avail_q    <= (cnt_ext >= AMOUNT_OF_ONCE);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q] <= rgb_in;
        end
    end

    assign rgb_ready  = ready_q;
    assign overflow   = overflow_q;
    assign kick       = (state_q == S_KICK);
    assign final_o    = (state_q == S_END);
    assign write_num  = AMOUNT_OF_ONCE;
    assign write_addr = {offset_q[29:0], 2'b00} + base_addr_q;
    assign buf_din    = mem[rd_ptr_q];
    assign fifo_cnt   = cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_rgb2dram.sv
// Directed-sequence bench for rgb2dram with random pixel data, checked against a queue model
// of FIFO contents and an address model derived from burst index and frame base.
module tb_rgb2dram;

    localparam logic [31:0] BURST    = 32'd64;
    localparam int          DEPTH    = 256;
    localparam logic [31:0] OFF_END  = 32'd1024;

    logic        clk;
    logic        rst;
    logic [31:0] rgb_in;
    logic        rgb_we;
    logic        rgb_ready;
    logic        overflow;
    logic        kick;
    logic        busy;
    logic [31:0] write_num;
    logic [31:0] write_addr;
    logic [31:0] buf_din;
    logic        buf_re;
    logic        frame_select;
    logic        final_o;
    logic [8:0]  fifo_cnt;
    logic [2:0]  state_o;

    logic [31:0] exp_q[$];
    int          tests;
    int          fails;
    int          kicks;
    logic [31:0] last_addr;

    rgb2dram #(
        .AMOUNT_OF_ONCE(BURST),
        .FIFO_DEPTH(DEPTH),
        .OFFSET_END(OFF_END)
    ) dut (
        .clk(clk), .rst(rst), .rgb_in(rgb_in), .rgb_we(rgb_we), .rgb_ready(rgb_ready),
        .overflow(overflow), .kick(kick), .busy(busy), .write_num(write_num),
        .write_addr(write_addr), .buf_din(buf_din), .buf_re(buf_re),
        .frame_select(frame_select), .final_o(final_o), .fifo_cnt(fifo_cnt), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic fs);
        rst = 1'b1; frame_select = fs; rgb_we = 1'b0; buf_re = 1'b0; busy = 1'b0; rgb_in = '0;
        step();
        step();
        check("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        check("rst_kick", 32'(kick), 32'd0);
        check("rst_final", 32'(final_o), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_ready", 32'(rgb_ready), 32'd0);
        check("rst_addr", write_addr, fs ? 32'h0 : 32'h100_0000);
        rst = 1'b0;
        exp_q.delete();
        step();
        step();
        check("ready_after_rst", 32'(rgb_ready), 32'd1);
    endtask

    task automatic push_word(input logic [31:0] d);
        logic accept;
        accept = exp_q.size() < DEPTH;
        check("rgb_ready", 32'(rgb_ready), 32'(accept));
        rgb_in = d; rgb_we = 1'b1;
        step();
        rgb_we = 1'b0;
        if (accept) exp_q.push_back(d);
    endtask

    task automatic push_n(input int n, input int gaps);
        for (int i = 0; i < n; i++) begin
            push_word($urandom);
            if (gaps != 0 && $urandom_range(0, 3) == 0) step();
        end
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_model_empty"}, 32'd1, 32'd0);
        end else begin
            check(tag, buf_din, exp_q[0]);
            buf_re = 1'b1;
            step();
            buf_re = 1'b0;
            void'(exp_q.pop_front());
        end
    endtask

    // Model DRAM writer: accept kick, raise busy, pull one burst, release busy.
    task automatic serve_burst(input logic [31:0] exp_addr, input int npops);
        int n;
        n = 0;
        while (!kick && n < 40) begin step(); n++; end
        check("kick_seen", 32'(kick), 32'd1);
        if (kick) kicks++;
        check("write_addr", write_addr, exp_addr);
        check("write_num", write_num, BURST);
        last_addr = write_addr;
        busy = 1'b1;
        n = 0;
        while (kick && n < 6) begin step(); n++; end
        check("kick_drop_cycles", 32'(n <= 3 && !kick), 32'd1);
        for (int i = 0; i < npops; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            pop_check("buf_din");
        end
    endtask

    task automatic end_burst();
        busy = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        int n;
        logic [31:0] d;
        tests = 0; fails = 0; kicks = 0; last_addr = '0;

        // 1) single burst, frame_select=1
        do_reset(1'b1);
        push_n(64, 0);
        check("latency_e0", 32'(kick), 32'd0);
        step();
        check("latency_e1", 32'(kick), 32'd0);
        serve_burst(32'h0, 64);
        end_burst();
        check("t1_cnt_empty", 32'(fifo_cnt), 32'd0);

        // 2) two bursts from base 0x100_0000
        do_reset(1'b0);
        push_n(128, 1);
        serve_burst(32'h100_0000, 64);
        end_burst();
        serve_burst(32'h100_0100, 64);
        end_burst();
        check("t2_cnt_empty", 32'(fifo_cnt), 32'd0);

        // 3) fill to full, overflow, push+pop while full
        do_reset(1'b1);
        push_n(256, 0);
        check("t3_cnt_full", 32'(fifo_cnt), 32'd256);
        check("t3_ready_low", 32'(rgb_ready), 32'd0);
        check("t3_no_ovf_yet", 32'(overflow), 32'd0);
        push_word(32'hdead_beef);
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_cnt_still_full", 32'(fifo_cnt), 32'd256);
        rgb_in = 32'h1234_5678; rgb_we = 1'b1;
        pop_check("t3_pop_full");
        rgb_we = 1'b0;
        check("t3_cnt_after_pushpop", 32'(fifo_cnt), 32'd255);
        step();
        check("t3_head", buf_din, exp_q[0]);

        // 4) simultaneous push+pop at 10, pop on empty
        do_reset(1'b0);
        push_n(10, 0);
        d = $urandom;
        rgb_in = d; rgb_we = 1'b1;
        pop_check("t4_pushpop_head");
        rgb_we = 1'b0;
        exp_q.push_back(d);
        check("t4_cnt10", 32'(fifo_cnt), 32'd10);
        for (int i = 0; i < 10; i++) pop_check("t4_drain");
        check("t4_cnt0", 32'(fifo_cnt), 32'd0);
        buf_re = 1'b1;
        step();
        buf_re = 1'b0;
        check("t4_empty_pop", 32'(fifo_cnt), 32'd0);
        check("t4_no_kick", 32'(kick), 32'd0);

        // 5) whole (scaled) frame
        do_reset(1'b0);
        kicks = 0;
        for (int b = 0; b < 32'(OFF_END / BURST); b++) begin
            push_n(64, 1);
            check("t5_final_early", 32'(final_o), 32'd0);
            serve_burst(32'h100_0000 + 32'(b) * (BURST * 4), 64);
            end_burst();
        end
        n = 0;
        while (!final_o && n < 20) begin step(); n++; end
        check("t5_final", 32'(final_o), 32'd1);
        check("t5_kicks", 32'(kicks), OFF_END / BURST);
        check("t5_last_addr", last_addr, 32'h100_0000 + (OFF_END - BURST) * 4);
        push_n(64, 0);
        repeat (10) step();
        check("t5_no_more_kick", 32'(kick), 32'd0);
        check("t5_final_hold", 32'(final_o), 32'd1);
        check("t5_cnt_after_end", 32'(fifo_cnt), 32'd64);

        // 6) reset mid-drain
        do_reset(1'b1);
        push_n(64, 0);
        serve_burst(32'h0, 20);
        rst = 1'b1;
        step();
        check("t6_cnt", 32'(fifo_cnt), 32'd0);
        check("t6_kick", 32'(kick), 32'd0);
        check("t6_addr", write_addr, 32'h0);
        busy = 1'b0;
        do_reset(1'b1);
        push_n(64, 1);
        serve_burst(32'h0, 64);
        end_burst();
        check("t6_restart_cnt", 32'(fifo_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
